multicycle_exec_unit: RTL and testbench
=======================================

Name: multicycle_exec_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle arithmetic/memory datapath.
- Accepts one 32-bit instruction at a time over a valid/ready handshake, then sequences it through execute, optional memory wait and writeback.
- Holds its own register file and data memory; memory latency is configurable.
- Reports result, destination, flags and an error bit on a one-cycle result strobe. Sits between the fetch/PC logic and the top-level control.

Parameters:
- DATA_W, 32, datapath and register width (>=8).
- NREGS, 32, register count; power of 2, <=32.
- MEM_DEPTH, 256, data memory words; power of 2.
- MEM_LAT, 2, data memory access cycles (1..8).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  unit can accept an instruction.
- instr  in  32  [31:26] opcode, [25:21] rs (destination / store source), [20:16] rt (source 1), [15:0] imm.
- pc_in  in  DATA_W  PC of the offered instruction.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  DATA_W  value written back (store: address used).
- res_reg  out  5  destination register index.
- flags  out  3  {carry, zero, sign} of the last ALU op.
- err  out  1  qualified by res_valid; illegal opcode.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - Outputs res_valid=0, err=0, flags=0, res_data=0, res_reg=0; instr_ready=1 in IDLE.
  - All registers clear to 0. Memory is not cleared.
  - Reset mid-operation aborts: no register write; a store not yet committed is dropped.
- States: IDLE, EXEC, MEM_WAIT, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr and pc_in, go to EXEC. No other state accepts an instruction.
- EXEC (1 cycle):
  - Read operands A=R[rt], B=R[rs] or imm.
  - Compute ALU result or memory address.
  - LD/ST go to MEM_WAIT with counter=MEM_LAT-1; all others go to WB.
- MEM_WAIT:
  - Counter decrements each cycle.
  - When counter==0: ST writes mem, LD captures read data, go to WB.
- WB (1 cycle):
  - Register write, res_valid=1, then IDLE.
- Latency from the accept edge: res_valid at accept+2 for ALU ops, accept+2+MEM_LAT for LD/ST. Next accept at one cycle after res_valid.
- Opcodes:
  - 0x01 ADD R[rs]=R[rt]+R[rs]
  - 0x02 SUB R[rt]-R[rs]
  - 0x03 AND
  - 0x04 OR
  - 0x05 XOR
  - 0x06 SLL R[rt]<<R[rs][4:0]
  - 0x07 SRA, arithmetic
  - 0x08 ADDI R[rt]+zext(imm)
  - 0x09 LD R[rs]=mem[addr]
  - 0x0A ST mem[addr]=R[rs], no register write
  - 0x0B LINK R[31]=pc_in+1
- Arithmetic and width rules:
  - imm zero-extended to DATA_W.
  - addr=(R[rt]+zext(imm)) mod MEM_DEPTH, so addresses wrap.
  - Arithmetic is modulo 2^DATA_W.
  - Carry is the carry-out for ADD/ADDI and the borrow-out for SUB; 0 for the others.
  - Zero and sign come from the result.
  - Flags update only on 0x01-0x08.
- Register index rules:
  - Indices >= NREGS alias modulo NREGS.
  - LINK targets NREGS-1.
- Illegal opcode: no register or memory write, flags unchanged, WB asserts err=1 with res_data=0.
- Same-register reuse: a writeback completes before the next accept, so no hazard exists.
- res_data and res_reg hold their values until the next WB.

Optional Feature:
- Macro: MULTICYCLE_EXEC_UNIT_MUL_EN.
- When defined:
  - Opcode 0x0C MUL: R[rs]=low DATA_W bits of R[rt]*R[rs].
  - Implemented as an iterative shift-add in an extra MUL state, exactly DATA_W cycles, between EXEC and WB.
  - Carry=1 if the high half is nonzero.
- When undefined: 0x0C is illegal (err=1) and no multiplier hardware is present.

Decomposition:
- Package multicycle_exec_pkg holds:
  - opcode localparams;
  - state encoding;
  - flag bit positions (CARRY=2, ZERO=1, SIGN=0).
- Sub-module exec_regfile: NREGS x DATA_W, two combinational read ports, one synchronous write port, async reset clear.
- ALU and memory stay inline.

Test Plan:
- ADD with instr_valid held high: reset, ADDI R1=R0+5, ADDI R2=R0+7, ADD rs=2 rt=1 -> res_data=12, res_reg=2, flags=000. Each res_valid lands 2 cycles after its accept; instr_ready=0 while busy.
- SUB borrow: R1=3, R2=5, SUB rs=2 rt=1 -> res_data=DATA_W'hFFFF_FFFE, flags=101.
- Store/load with MEM_LAT=2 and MEM_DEPTH=256:
  - ST rs=2 (R2=0xAB), rt=0, imm=0x0103 -> mem[3]=0xAB (address wraps).
  - LD rs=4, imm=3 -> R4=0xAB, res_valid exactly 4 cycles after accept.
- Illegal opcode and LINK:
  - Opcode 0x3F -> err=1, res_data=0, no register change.
  - LINK with pc_in=0x10 -> R31=0x11, res_reg=31.
- Reset mid-operation: assert reset during the MEM_WAIT of an ST to 0x05 -> mem[5] unchanged, state IDLE, all registers 0, res_valid stays 0.
- MUL with MULTICYCLE_EXEC_UNIT_MUL_EN: R1=0x10000, R2=0x10000, MUL -> res_data=0, carry=1, res_valid at accept+2+DATA_W. Without the macro, the same opcode gives err=1.

Source files
------------

// File: rtl/multicycle_exec_pkg.sv
// Shared definitions for the multi-cycle execution unit: opcodes, FSM state
// encoding, flag bit positions and small opcode-decode helpers.
// Optional feature macro: MULTICYCLE_EXEC_UNIT_MUL_EN (adds the iterative MUL opcode).
package multicycle_exec_pkg;

  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_SLL  = 6'h06;
  localparam logic [5:0] OP_SRA  = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LD   = 6'h09;
  localparam logic [5:0] OP_ST   = 6'h0A;
  localparam logic [5:0] OP_LINK = 6'h0B;
  localparam logic [5:0] OP_MUL  = 6'h0C;

  // Bit positions inside the 3-bit flags word {carry, zero, sign}
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_SIGN  = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXEC     = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_WB       = 3'd3,
    ST_MUL      = 3'd4
  } state_e;

  // True for every opcode the current build implements
  function automatic logic op_is_legal(input logic [5:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRA, OP_ADDI,
      OP_LD, OP_ST, OP_LINK: legal = 1'b1;
`ifdef MULTICYCLE_EXEC_UNIT_MUL_EN
      OP_MUL: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Opcodes whose result updates the flags word (callers also qualify with legality)
  function automatic logic op_sets_flags(input logic [5:0] op);
    return ((op >= OP_ADD) && (op <= OP_ADDI)) || (op == OP_MUL);
  endfunction

  // Opcodes that pass through the data-memory wait state
  function automatic logic op_is_mem(input logic [5:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/exec_regfile.sv
// Register file for the multi-cycle execution unit: NREGS x DATA_W,
// two combinational read ports, one synchronous write port, async clear.
module exec_regfile #(
  parameter int NREGS  = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_a_idx_i,
  output logic [DATA_W-1:0] rd_a_data_o,
  input  logic [IDX_W-1:0]  rd_b_idx_i,
  output logic [DATA_W-1:0] rd_b_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] regs_q [NREGS];

  assign rd_a_data_o = regs_q[rd_a_idx_i];
  assign rd_b_data_o = regs_q[rd_b_idx_i];

  // Register storage: cleared on reset, one write per cycle otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      regs_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/multicycle_exec_unit.sv
// Multi-cycle execution unit: accepts one instruction over valid/ready,
// sequences it through EXEC, optional MEM_WAIT (or MUL) and WB, and reports
// the result on a one-cycle strobe. Holds its own register file and data memory.
// Optional feature macro: MULTICYCLE_EXEC_UNIT_MUL_EN (iterative shift-add MUL, opcode 0x0C).
module multicycle_exec_unit
  import multicycle_exec_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NREGS     = 32,
  parameter int MEM_DEPTH = 256,
  parameter int MEM_LAT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_in,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [4:0]        res_reg,
  output logic [2:0]        flags,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = $clog2(DATA_W + 9);
  localparam logic [CNT_W-1:0] MEM_CNT_INIT = CNT_W'(MEM_LAT - 1);
`ifdef MULTICYCLE_EXEC_UNIT_MUL_EN
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(DATA_W - 1);
`endif

  // Sequencing state and latched instruction
  state_e            state_q;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] pc_q;
  logic [CNT_W-1:0]  cnt_q;

  // Values carried from EXEC / MEM_WAIT / MUL into WB
  logic [DATA_W-1:0] result_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] st_data_q;
  logic [2:0]        flag_pend_q;
  logic [IDX_W-1:0]  dest_q;
  logic              illegal_q;
  logic              set_flags_q;
  logic              wr_en_q;

  // Registered outputs
  logic              ready_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;
  logic [4:0]        res_reg_q;
  logic [2:0]        flags_q;
  logic              err_q;
  logic              busy_q;

`ifdef MULTICYCLE_EXEC_UNIT_MUL_EN
  logic [2*DATA_W-1:0] mul_acc_q;
  logic [2*DATA_W-1:0] mul_mcand_q;
  logic [DATA_W-1:0]   mul_mplier_q;
  logic [2*DATA_W-1:0] mul_acc_next_s;
  logic [2:0]          mul_flag_s;
`endif

  // Decoded fields of the latched instruction
  logic [5:0]        op_s;
  logic [IDX_W-1:0]  rs_idx_s;
  logic [IDX_W-1:0]  rt_idx_s;
  logic [15:0]       imm_s;
  logic [DATA_W-1:0] imm_ext_s;

  assign op_s      = instr_q[31:26];
  assign rs_idx_s  = instr_q[21 +: IDX_W];
  assign rt_idx_s  = instr_q[16 +: IDX_W];
  assign imm_s     = instr_q[15:0];
  assign imm_ext_s = DATA_W'(imm_s);

  // Operands: A = R[rt], B = R[rs]
  logic [DATA_W-1:0] opa_s;
  logic [DATA_W-1:0] opb_s;
  logic              rf_we_s;

  assign rf_we_s = (state_q == ST_WB) && wr_en_q;

  exec_regfile #(
    .NREGS  (NREGS),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk         (clk),
    .reset       (reset),
    .rd_a_idx_i  (rt_idx_s),
    .rd_a_data_o (opa_s),
    .rd_b_idx_i  (rs_idx_s),
    .rd_b_data_o (opb_s),
    .wr_en_i     (rf_we_s),
    .wr_idx_i    (dest_q),
    .wr_data_i   (result_q)
  );

  // ALU result and carry/borrow for the opcode held in instr_q
  logic [DATA_W-1:0] alu_s;
  logic              carry_s;

  always_comb begin
    alu_s   = '0;
    carry_s = 1'b0;
    case (op_s)
      OP_ADD:  {carry_s, alu_s} = {1'b0, opa_s} + {1'b0, opb_s};
      OP_SUB:  {carry_s, alu_s} = {1'b0, opa_s} - {1'b0, opb_s};
      OP_AND:  alu_s = opa_s & opb_s;
      OP_OR:   alu_s = opa_s | opb_s;
      OP_XOR:  alu_s = opa_s ^ opb_s;
      OP_SLL:  alu_s = opa_s << opb_s[4:0];
      OP_SRA:  alu_s = $signed(opa_s) >>> opb_s[4:0];
      OP_ADDI: {carry_s, alu_s} = {1'b0, opa_s} + {1'b0, imm_ext_s};
      OP_LINK: alu_s = pc_q + DATA_W'(1);
      default: begin
        alu_s   = '0;
        carry_s = 1'b0;
      end
    endcase
  end

  // Flags word produced by the current ALU result
  logic [2:0] flag_new_s;

  always_comb begin
    flag_new_s             = 3'b000;
    flag_new_s[FLAG_CARRY] = carry_s;
    flag_new_s[FLAG_ZERO]  = (alu_s == '0);
    flag_new_s[FLAG_SIGN]  = alu_s[DATA_W-1];
  end

  // Memory address wraps naturally by keeping only the low AW bits of R[rt]+imm
  logic [AW-1:0] addr_s;
  assign addr_s = opa_s[AW-1:0] + imm_ext_s[AW-1:0];

  // Data memory (not cleared by reset)
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] mem_rd_s;
  logic              mem_we_s;

  assign mem_rd_s = mem_q[addr_q];
  assign mem_we_s = (state_q == ST_MEM_WAIT) && (cnt_q == '0) && (op_s == OP_ST);

`ifdef MULTICYCLE_EXEC_UNIT_MUL_EN
  // One shift-add step of the multiplier and the flags of the finished product
  always_comb begin
    mul_acc_next_s = mul_mplier_q[0] ? (mul_acc_q + mul_mcand_q) : mul_acc_q;
    mul_flag_s             = 3'b000;
    mul_flag_s[FLAG_CARRY] = (mul_acc_next_s[2*DATA_W-1:DATA_W] != '0);
    mul_flag_s[FLAG_ZERO]  = (mul_acc_next_s[DATA_W-1:0] == '0);
    mul_flag_s[FLAG_SIGN]  = mul_acc_next_s[DATA_W-1];
  end
`endif

  // Store commit at the last MEM_WAIT cycle; state is IDLE while reset is held
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[addr_q] <= st_data_q;
    end
  end

  // Main sequencer: IDLE -> EXEC -> (MEM_WAIT | MUL) -> WB, with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      instr_q     <= 32'h0000_0000;
      pc_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      addr_q      <= '0;
      st_data_q   <= '0;
      flag_pend_q <= 3'b000;
      dest_q      <= '0;
      illegal_q   <= 1'b0;
      set_flags_q <= 1'b0;
      wr_en_q     <= 1'b0;
      ready_q     <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_reg_q   <= 5'd0;
      flags_q     <= 3'b000;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MULTICYCLE_EXEC_UNIT_MUL_EN
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
`endif
    end else begin
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (instr_valid && ready_q) begin
            instr_q <= instr;
            pc_q    <= pc_in;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q    <= alu_s;
          flag_pend_q <= flag_new_s;
          illegal_q   <= !op_is_legal(op_s);
          set_flags_q <= op_is_legal(op_s) && op_sets_flags(op_s);
          wr_en_q     <= op_is_legal(op_s) && (op_s != OP_ST);
          dest_q      <= (op_s == OP_LINK) ? IDX_W'(NREGS - 1) : rs_idx_s;
          if (op_is_mem(op_s)) begin
            result_q  <= DATA_W'(addr_s);
            addr_q    <= addr_s;
            st_data_q <= opb_s;
            cnt_q     <= MEM_CNT_INIT;
            state_q   <= ST_MEM_WAIT;
`ifdef MULTICYCLE_EXEC_UNIT_MUL_EN
          end else if (op_s == OP_MUL) begin
            mul_acc_q    <= '0;
            mul_mcand_q  <= {{DATA_W{1'b0}}, opa_s};
            mul_mplier_q <= opb_s;
            cnt_q        <= MUL_CNT_INIT;
            state_q      <= ST_MUL;
`endif
          end else begin
            state_q <= ST_WB;
          end
        end
        ST_MEM_WAIT: begin
          if (cnt_q == '0) begin
            if (op_s == OP_LD) begin
              result_q <= mem_rd_s;
            end
            state_q <= ST_WB;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`ifdef MULTICYCLE_EXEC_UNIT_MUL_EN
        ST_MUL: begin
          mul_acc_q    <= mul_acc_next_s;
          mul_mcand_q  <= mul_mcand_q << 1;
          mul_mplier_q <= mul_mplier_q >> 1;
          if (cnt_q == '0) begin
            result_q    <= mul_acc_next_s[DATA_W-1:0];
            flag_pend_q <= mul_flag_s;
            state_q     <= ST_WB;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`endif
        ST_WB: begin
          res_valid_q <= 1'b1;
          res_data_q  <= result_q;
          res_reg_q   <= 5'(dest_q);
          err_q       <= illegal_q;
          if (set_flags_q) begin
            flags_q <= flag_pend_q;
          end
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_reg     = res_reg_q;
  assign flags       = flags_q;
  assign err         = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_multicycle_exec_unit.sv
// Self-checking bench for multicycle_exec_unit: a table of hand-computed
// vectors, hand-written reset/hold sequences, then random instructions
// checked against a behavioural model of registers, memory and flags.
module tb_multicycle_exec_unit;

  localparam int MEM_LAT = 2;
  localparam int DW      = 32;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        res_valid;
  logic [31:0] res_data;
  logic [4:0]  res_reg;
  logic [2:0]  flags;
  logic        err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  multicycle_exec_unit #(
    .DATA_W    (32),
    .NREGS     (32),
    .MEM_DEPTH (256),
    .MEM_LAT   (MEM_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc_in       (pc_in),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_reg     (res_reg),
    .flags       (flags),
    .err         (err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rg;
    logic [2:0]  fl;
    bit          err;
    int          lat;
    bit          chk_reg;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] pc;
    bit          hold;
    exp_t        e;
  } vec_t;

  // Behavioural model state
  logic [31:0] mreg [32];
  logic [31:0] mmem [256];
  int          wlist [$];
  logic [2:0]  mflags;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    mflags = 3'b000;
  endtask

  // Executes one instruction on the model and returns what the DUT must report
  task automatic model_exec(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [15:0] imm, input logic [31:0] pc, output exp_t e);
    logic [31:0] a, b, res;
    longint unsigned s;
    bit c, wr, fl;
    int addr;
    a = mreg[rt];
    b = mreg[rs];
    res = 32'h0; c = 1'b0; wr = 1'b1; fl = 1'b1;
    e.err = 1'b0; e.rg = rs; e.lat = 2; e.chk_reg = 1'b1;
    addr = int'((longint'(a) + longint'(imm)) % 256);
    case (op)
      6'h01: begin s = longint'(a) + longint'(b); res = s[31:0]; c = (s > 64'hFFFF_FFFF); end
      6'h02: begin res = a - b; c = (a < b); end
      6'h03: res = a & b;
      6'h04: res = a | b;
      6'h05: res = a ^ b;
      6'h06: res = a << b[4:0];
      6'h07: res = 32'($signed(a) >>> b[4:0]);
      6'h08: begin s = longint'(a) + longint'(imm); res = s[31:0]; c = (s > 64'hFFFF_FFFF); end
      6'h09: begin res = mmem[addr]; fl = 1'b0; e.lat = 2 + MEM_LAT; end
      6'h0A: begin
        mmem[addr] = b; wlist.push_back(addr);
        res = addr; wr = 1'b0; fl = 1'b0; e.lat = 2 + MEM_LAT;
      end
      6'h0B: begin res = pc + 32'd1; e.rg = 5'd31; fl = 1'b0; end
`ifdef MULTICYCLE_EXEC_UNIT_MUL_EN
      6'h0C: begin
        s = longint'(a) * longint'(b); res = s[31:0]; c = ((s >> 32) != 0); e.lat = 2 + DW;
      end
`endif
      default: begin res = 32'h0; wr = 1'b0; fl = 1'b0; e.err = 1'b1; e.chk_reg = 1'b0; end
    endcase
    if (wr) mreg[e.rg] = res;
    if (fl) mflags = {c, (res == 32'h0), res[31]};
    e.data = res;
    e.fl = mflags;
  endtask

  // Offers one instruction (DUT must be idle), waits for the strobe and checks it
  task automatic run_check(input string nm, input logic [5:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [15:0] imm, input logic [31:0] pc,
                           input bit hold, input exp_t e);
    int n;
    bit got, busy_ok;
    chk({nm, ".ready"}, 64'(instr_ready), 64'd1);
    instr_valid = 1'b1;
    instr = {op, rs, rt, imm};
    pc_in = pc;
    @(posedge clk); #1;
    if (!hold) instr_valid = 1'b0;
    n = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && n < 200) begin
      if (instr_ready !== 1'b0 || busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
      if (res_valid === 1'b1) got = 1'b1;
    end
    chk({nm, ".busy"}, 64'(busy_ok), 64'd1);
    if (!got) begin
      chk({nm, ".timeout"}, 64'(n), 64'(e.lat));
      return;
    end
    chk({nm, ".lat"}, 64'(n), 64'(e.lat));
    chk({nm, ".data"}, 64'(res_data), 64'(e.data));
    if (e.chk_reg) chk({nm, ".reg"}, 64'(res_reg), 64'(e.rg));
    chk({nm, ".flags"}, 64'(flags), 64'(e.fl));
    chk({nm, ".err"}, 64'(err), 64'(e.err));
  endtask

  task automatic run_model(input string nm, input logic [5:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [15:0] imm, input logic [31:0] pc);
    exp_t e;
    model_exec(op, rs, rt, imm, pc, e);
    run_check(nm, op, rs, rt, imm, pc, 1'b0, e);
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [15:0] imm, input logic [31:0] pc, input bit hold,
                              input logic [31:0] data, input logic [4:0] rg, input logic [2:0] fl,
                              input bit er, input int lat);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.imm = imm; v.pc = pc; v.hold = hold;
    v.e.data = data; v.e.rg = rg; v.e.fl = fl; v.e.err = er; v.e.lat = lat; v.e.chk_reg = !er;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [$];
    exp_t dummy;
    bit quiet;

    // Hand-computed vectors; register state carries from one row to the next
    tbl.push_back(mk(6'h08, 5'd1,  5'd0,  16'h0005, 32'h0, 1'b1, 32'h0000_0005, 5'd1,  3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h08, 5'd2,  5'd0,  16'h0007, 32'h0, 1'b1, 32'h0000_0007, 5'd2,  3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h01, 5'd2,  5'd1,  16'h0000, 32'h0, 1'b0, 32'h0000_000C, 5'd2,  3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h08, 5'd1,  5'd0,  16'h0003, 32'h0, 1'b0, 32'h0000_0003, 5'd1,  3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h08, 5'd2,  5'd0,  16'h0005, 32'h0, 1'b0, 32'h0000_0005, 5'd2,  3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h02, 5'd2,  5'd1,  16'h0000, 32'h0, 1'b0, 32'hFFFF_FFFE, 5'd2,  3'b101, 1'b0, 2));
    tbl.push_back(mk(6'h08, 5'd2,  5'd0,  16'h00AB, 32'h0, 1'b0, 32'h0000_00AB, 5'd2,  3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h0A, 5'd2,  5'd0,  16'h0103, 32'h0, 1'b0, 32'h0000_0003, 5'd2,  3'b000, 1'b0, 4));
    tbl.push_back(mk(6'h09, 5'd4,  5'd0,  16'h0003, 32'h0, 1'b0, 32'h0000_00AB, 5'd4,  3'b000, 1'b0, 4));
    tbl.push_back(mk(6'h3F, 5'd4,  5'd1,  16'h0000, 32'h0, 1'b0, 32'h0000_0000, 5'd4,  3'b000, 1'b1, 2));
    tbl.push_back(mk(6'h08, 5'd5,  5'd4,  16'h0000, 32'h0, 1'b0, 32'h0000_00AB, 5'd5,  3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h0B, 5'd0,  5'd0,  16'h0000, 32'h10, 1'b0, 32'h0000_0011, 5'd31, 3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h08, 5'd6,  5'd31, 16'h0001, 32'h0, 1'b0, 32'h0000_0012, 5'd6,  3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h02, 5'd5,  5'd4,  16'h0000, 32'h0, 1'b0, 32'h0000_0000, 5'd5,  3'b010, 1'b0, 2));
    tbl.push_back(mk(6'h08, 5'd7,  5'd0,  16'hFFFF, 32'h0, 1'b0, 32'h0000_FFFF, 5'd7,  3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h08, 5'd8,  5'd0,  16'h0010, 32'h0, 1'b0, 32'h0000_0010, 5'd8,  3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h06, 5'd8,  5'd7,  16'h0000, 32'h0, 1'b0, 32'hFFFF_0000, 5'd8,  3'b001, 1'b0, 2));
    tbl.push_back(mk(6'h01, 5'd8,  5'd8,  16'h0000, 32'h0, 1'b0, 32'hFFFE_0000, 5'd8,  3'b101, 1'b0, 2));
    tbl.push_back(mk(6'h08, 5'd9,  5'd0,  16'h0004, 32'h0, 1'b0, 32'h0000_0004, 5'd9,  3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h07, 5'd9,  5'd8,  16'h0000, 32'h0, 1'b0, 32'hFFFF_E000, 5'd9,  3'b001, 1'b0, 2));
    tbl.push_back(mk(6'h03, 5'd9,  5'd7,  16'h0000, 32'h0, 1'b0, 32'h0000_E000, 5'd9,  3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h04, 5'd9,  5'd1,  16'h0000, 32'h0, 1'b0, 32'h0000_E003, 5'd9,  3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h05, 5'd9,  5'd9,  16'h0000, 32'h0, 1'b0, 32'h0000_0000, 5'd9,  3'b010, 1'b0, 2));
    tbl.push_back(mk(6'h08, 5'd1,  5'd0,  16'h0001, 32'h0, 1'b0, 32'h0000_0001, 5'd1,  3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h08, 5'd10, 5'd0,  16'h0010, 32'h0, 1'b0, 32'h0000_0010, 5'd10, 3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h06, 5'd10, 5'd1,  16'h0000, 32'h0, 1'b0, 32'h0001_0000, 5'd10, 3'b000, 1'b0, 2));
    tbl.push_back(mk(6'h08, 5'd11, 5'd10, 16'h0000, 32'h0, 1'b0, 32'h0001_0000, 5'd11, 3'b000, 1'b0, 2));
`ifdef MULTICYCLE_EXEC_UNIT_MUL_EN
    tbl.push_back(mk(6'h0C, 5'd11, 5'd10, 16'h0000, 32'h0, 1'b0, 32'h0000_0000, 5'd11, 3'b110, 1'b0, 2 + DW));
`else
    tbl.push_back(mk(6'h0C, 5'd11, 5'd10, 16'h0000, 32'h0, 1'b0, 32'h0000_0000, 5'd11, 3'b000, 1'b1, 2));
`endif

    // Reset and its output values
    reset = 1'b1; instr_valid = 1'b0; instr = 32'h0; pc_in = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 64'(instr_ready), 64'd1);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.res_valid", 64'(res_valid), 64'd0);
    chk("rst.outs", {27'h0, err, flags, res_reg, res_data}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table vectors; the model is stepped alongside so later phases stay in sync
    for (int i = 0; i < tbl.size(); i++) begin
      model_exec(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].imm, tbl[i].pc, dummy);
      run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].imm,
                tbl[i].pc, tbl[i].hold, tbl[i].e);
    end
    instr_valid = 1'b0;

    // Result outputs hold after the strobe
    repeat (3) @(posedge clk);
    #1;
    chk("hold.res_valid", 64'(res_valid), 64'd0);
    chk("hold.res_data", 64'(res_data), 64'(tbl[tbl.size()-1].e.data));

    // Reset in the middle of a store's memory wait must drop the store
    run_model("pre.addi", 6'h08, 5'd2, 5'd0, 16'h0055, 32'h0);
    run_model("pre.st",   6'h0A, 5'd2, 5'd0, 16'h0005, 32'h0);
    run_model("pre.addi3", 6'h08, 5'd3, 5'd0, 16'h0077, 32'h0);
    instr_valid = 1'b1;
    instr = {6'h0A, 5'd3, 5'd0, 16'h0005};
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid.busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid.ready", 64'(instr_ready), 64'd1);
    chk("mid.idle", 64'(busy), 64'd0);
    chk("mid.outs", {26'h0, res_valid, err, flags, res_reg, res_data}, 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b0) quiet = 1'b0;
    end
    chk("mid.no_strobe", 64'(quiet), 64'd1);
    run_model("post.ld", 6'h09, 5'd1, 5'd0, 16'h0005, 32'h0);
    run_model("post.r3", 6'h08, 5'd4, 5'd3, 16'h0000, 32'h0);

    // Random instructions against the model
    for (int i = 0; i < 80; i++) begin
      int sel;
      logic [5:0] op;
      logic [4:0] rs, rt;
      logic [15:0] imm;
      logic [31:0] pc;
      sel = $urandom_range(0, 12);
      op = (sel <= 10) ? 6'(sel + 1) : ((sel == 11) ? 6'h0C : 6'h3F);
      rs = 5'($urandom_range(0, 31));
      rt = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      pc = $urandom;
      if (op == 6'h09) begin
        int tgt;
        logic [7:0] lo;
        tgt = wlist[$urandom_range(0, wlist.size() - 1)];
        lo = 8'(tgt) - mreg[rt][7:0];
        imm = {8'($urandom), lo};
      end
      run_model($sformatf("rnd%0d", i), op, rs, rt, imm, pc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
